// File: rtl/uart_tx_module.sv
// UART transmit serializer.
// Sends start bit, 5..8 data bits LSB first, optional even parity and
// 1 / 1.5 / 2 stop bits. Bit timing is 16 baud_en_i ticks per bit.
//
// Ports:
//   clk_i          system clock (rising edge)
//   rst_i          synchronous active-low reset
//   baud_en_i      16x oversample tick
//   tx_en_i        transmitter enable; gates frame start only
//   tx_start_i     start request / FIFO-not-empty
//   tx_conf_i      [4:3] data length, [2:1] stop bits, [0] parity enable
//   tx_data_i      word to send
//   tx_fifo_en_i   data sourced from external TX FIFO
//   tx_done_o      one-cycle pulse after the frame ends
//   tx_busy_o      frame in progress
//   uart_tx_o      serial line, idle high
//   tx_fifo_pop_o  one-cycle FIFO pop strobe at frame start
module uart_tx_module #(
  parameter int unsigned MAX_UART_DATA_W = 8,
  parameter int unsigned DATA_COUNTER_W  = 3,
  parameter int unsigned STOP_CONF_W     = 2,
  parameter int unsigned DATA_CONF_W     = 2,
  parameter int unsigned SAMPLE_COUNT_W  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 baud_en_i,
  input  logic                                 tx_en_i,
  input  logic                                 tx_start_i,
  input  logic [DATA_CONF_W+STOP_CONF_W:0]     tx_conf_i,
  input  logic [MAX_UART_DATA_W-1:0]           tx_data_i,
  input  logic                                 tx_fifo_en_i,
  output logic                                 tx_done_o,
  output logic                                 tx_busy_o,
  output logic                                 uart_tx_o,
  output logic                                 tx_fifo_pop_o
);

  localparam int unsigned CONF_W = DATA_CONF_W + STOP_CONF_W + 1;
  // One extra counter bit so the same counter can cover 2-bit stop periods.
  localparam int unsigned CNT_W  = SAMPLE_COUNT_W + 1;
  localparam int unsigned TICKS  = 1 << SAMPLE_COUNT_W;

  localparam logic [CNT_W-1:0] LAST_1BIT  = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] LAST_15BIT = CNT_W'(TICKS + TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_2BIT  = CNT_W'(2 * TICKS - 1);
  // Shortest frame's last bit index (5 data bits -> index 4).
  localparam logic [DATA_COUNTER_W-1:0] MIN_LAST =
    DATA_COUNTER_W'(MAX_UART_DATA_W - (1 << DATA_CONF_W));

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                      state_q, state_d;
  logic [MAX_UART_DATA_W-1:0]  data_q;
  logic [CONF_W-1:0]           conf_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [DATA_COUNTER_W-1:0]   bit_idx_q;
  logic                        done_q;
  logic                        pop_q;

  logic [CNT_W-1:0]            cnt_last;
  logic                        tick_end;
  logic                        start_frame;
  logic                        frame_end;
  logic                        tx_line;
  logic [DATA_COUNTER_W-1:0]   last_idx;
  logic [DATA_COUNTER_W-1:0]   in_last;
  logic [MAX_UART_DATA_W-1:0]  in_mask;

  assign last_idx = MIN_LAST + DATA_COUNTER_W'(conf_q[CONF_W-1 -: DATA_CONF_W]);

  // Unused high data bits are cleared at latch time, so parity is simply
  // the XOR of the whole latched word.
  always_comb begin
    in_last = MIN_LAST + DATA_COUNTER_W'(tx_conf_i[CONF_W-1 -: DATA_CONF_W]);
    in_mask = '0;
    for (int unsigned i = 0; i < MAX_UART_DATA_W; i++) begin
      in_mask[i] = (i <= 32'(in_last));
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    tx_line     = 1'b1;
    cnt_last    = LAST_1BIT;
    if (state_q == STOP) begin
      case (conf_q[STOP_CONF_W:1])
        STOP_CONF_W'(0): cnt_last = LAST_1BIT;
        STOP_CONF_W'(1): cnt_last = LAST_15BIT;
        default:         cnt_last = LAST_2BIT;
      endcase
    end
    tick_end = baud_en_i && (cnt_q == cnt_last);

    case (state_q)
      IDLE: begin
        if (tx_en_i && tx_start_i) begin
          state_d     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (tick_end) state_d = DATA;
      end
      DATA: begin
        tx_line = data_q[bit_idx_q];
        if (tick_end && (bit_idx_q == last_idx)) begin
          state_d = conf_q[0] ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_line = ^data_q;
        if (tick_end) state_d = STOP;
      end
      STOP: begin
        if (tick_end) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      conf_q    <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
      pop_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_end;
      pop_q   <= start_frame && tx_fifo_en_i;
      if (start_frame) begin
        data_q    <= tx_data_i & in_mask;
        conf_q    <= tx_conf_i;
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else if ((state_q != IDLE) && baud_en_i) begin
        cnt_q <= tick_end ? '0 : cnt_q + CNT_W'(1);
        if ((state_q == DATA) && tick_end) begin
          bit_idx_q <= (bit_idx_q == last_idx) ? '0 : bit_idx_q + DATA_COUNTER_W'(1);
        end
      end
    end
  end

  assign tx_busy_o     = (state_q != IDLE);
  assign tx_done_o     = done_q;
  assign tx_fifo_pop_o = pop_q;
  assign uart_tx_o     = tx_line;

endmodule

// File: tb/tb_uart_tx_module.sv
// Testbench for uart_tx_module: driver pushes expected frames into a
// scoreboard queue; a negedge monitor pops one per frame and checks the
// line level per oversample tick, busy/done/pop timing and reset state.
module tb_uart_tx_module;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       baud_en_i = 1'b0;
  logic       tx_en_i = 1'b0;
  logic       tx_start_i = 1'b0;
  logic [4:0] tx_conf_i = '0;
  logic [7:0] tx_data_i = '0;
  logic       tx_fifo_en_i = 1'b0;
  logic       tx_done_o, tx_busy_o, uart_tx_o, tx_fifo_pop_o;

  always #5 clk = ~clk;

  uart_tx_module #(
    .MAX_UART_DATA_W(8),
    .DATA_COUNTER_W (3),
    .STOP_CONF_W    (2),
    .DATA_CONF_W    (2),
    .SAMPLE_COUNT_W (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .baud_en_i    (baud_en_i),
    .tx_en_i      (tx_en_i),
    .tx_start_i   (tx_start_i),
    .tx_conf_i    (tx_conf_i),
    .tx_data_i    (tx_data_i),
    .tx_fifo_en_i (tx_fifo_en_i),
    .tx_done_o    (tx_done_o),
    .tx_busy_o    (tx_busy_o),
    .uart_tx_o    (uart_tx_o),
    .tx_fifo_pop_o(tx_fifo_pop_o)
  );

  typedef struct {
    logic [7:0] data;
    logic [4:0] conf;
    bit         fifo;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   baud_mode = 0;
  int   baud_phase = 0;

  // ---------------- reference model ----------------
  function automatic int data_len(input logic [4:0] c);
    return 5 + int'(c[4:3]);
  endfunction

  function automatic int stop_ticks(input logic [4:0] c);
    case (c[2:1])
      2'b00:   return 16;
      2'b01:   return 24;
      default: return 32;
    endcase
  endfunction

  function automatic int frame_ticks(input exp_t e);
    return 16 * (1 + data_len(e.conf) + int'(e.conf[0])) + stop_ticks(e.conf);
  endfunction

  function automatic logic expected_level(input exp_t e, input int k);
    int slot = k / 16;
    int len  = data_len(e.conf);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(e.data[i]);
    if (slot == 0) return 1'b0;
    if (slot <= len) return e.data[slot-1];
    if (e.conf[0] && slot == len + 1) return logic'(ones % 2);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- baud tick generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (baud_mode)
        0: baud_en_i = 1'b1;
        1: begin
          baud_phase = (baud_phase + 1) % 4;
          baud_en_i  = (baud_phase == 0);
        end
        default: baud_en_i = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit   in_frame = 0;
  bit   rst_pend = 0;
  bit   stray = 0;
  bit   first = 0;
  int   k = 0;
  int   cyc = 0;
  int   last_done = -100;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_pend) begin
        chk("reset_state", {uart_tx_o, tx_busy_o, tx_done_o, tx_fifo_pop_o}, 4'b1000);
        rst_pend = 0;
      end else begin
        if (!tx_busy_o) stray = 0;
        if (!in_frame && tx_busy_o && !stray) begin
          if (sb.size() == 0) begin
            chk_int("unexpected_frame", 1, 0);
            stray = 1;
          end else begin
            cur      = sb.pop_front();
            in_frame = 1;
            first    = 1;
            k        = 0;
            if (cur.b2b) chk_int("b2b_gap", cyc - last_done, 1);
          end
        end
        if (in_frame) begin
          if (k == frame_ticks(cur)) begin
            chk("frame_end", {uart_tx_o, tx_busy_o, tx_done_o, tx_fifo_pop_o}, 4'b1010);
            in_frame  = 0;
            last_done = cyc;
          end else begin
            chk("line", uart_tx_o, expected_level(cur, k));
            chk("busy_done", {tx_busy_o, tx_done_o}, 4'b0010);
            chk("pop", tx_fifo_pop_o, first ? cur.fifo : 1'b0);
            first = 0;
            if (baud_en_i) k++;
          end
        end else if (!tx_busy_o) begin
          chk("idle", {uart_tx_o, tx_busy_o, tx_done_o, tx_fifo_pop_o}, 4'b1000);
        end
      end
      if (rst_i == 1'b0) begin
        in_frame = 0;
        rst_pend = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (tx_busy_o !== 1'b0 && i < 6000) begin
      tick();
      i++;
    end
    chk(name, tx_busy_o, 1'b0);
  endtask

  task automatic wait_busy(input string name);
    int i = 0;
    while (tx_busy_o !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk(name, tx_busy_o, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] c);
    exp_t e;
    wait_idle("idle_before_send");
    tx_fifo_en_i = 1'b0;
    tx_data_i    = d;
    tx_conf_i    = c;
    tx_start_i   = 1'b1;
    e = '{data: d, conf: c, fifo: 1'b0, b2b: 1'b0};
    sb.push_back(e);
    tick();
    tx_start_i = 1'b0;
    // Scramble inputs mid-frame; the latched copies must be used.
    tx_data_i  = 8'($urandom);
    tx_conf_i  = 5'($urandom);
  endtask

  task automatic fifo_burst(input int n);
    exp_t e;
    wait_idle("idle_before_fifo");
    tx_fifo_en_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      e.data = 8'($urandom);
      e.conf = 5'($urandom);
      e.fifo = 1'b1;
      e.b2b  = (i > 0);
      sb.push_back(e);
      tx_data_i = e.data;
      tx_conf_i = e.conf;
      tx_start_i = 1'b1;
      wait_busy("fifo_busy");
      wait_idle("fifo_idle");
    end
    tx_start_i   = 1'b0;
    tx_fifo_en_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    tick(50);
    rst_i   = 1'b1;
    tx_en_i = 1'b1;
    baud_mode = 0;
    tick(2);

    send(8'hAA, 5'b11000);
    send(8'h13, 5'b00001);
    send(8'h00, 5'b11100);
    send(8'h00, 5'b11010);

    // Start while busy is ignored; dropping enable does not abort;
    // start with enable low never launches a frame.
    send(8'h3C, 5'b10000);
    tick(40);
    tx_start_i = 1'b1;
    tick();
    tx_start_i = 1'b0;
    tick(30);
    tx_en_i    = 1'b0;
    tx_start_i = 1'b1;
    wait_idle("en_drop_complete");
    tick(30);
    tx_start_i = 1'b0;
    tx_en_i    = 1'b1;

    fifo_burst(4);

    // Reset in the middle of the data bits.
    send(8'h5A, 5'b11000);
    tick(60);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick(5);

    baud_mode = 1;
    send(8'hC3, 5'b01101);

    for (int i = 0; i < 12; i++) begin
      baud_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) fifo_burst(2);
      else send(8'($urandom), 5'($urandom));
      tick($urandom_range(0, 5));
    end

    wait_idle("final_idle");
    tick(3);
    chk_int("sb_empty", sb.size(), 0);
    chk("monitor_idle", in_frame, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
UART transmit serializer. It takes a parallel data word and a runtime frame configuration and drives an asynchronous serial frame on uart_tx_o: start bit, 5–8 data bits LSB first, optional even parity, then 1/1.5/2 stop bits. Bit timing comes from an external 16x-oversample baud enable. The block sits between the UART register/FIFO front end and the TX pin.

Parameters:
MAX_UART_DATA_W, 8, width of tx_data_i (maximum data bits per frame)
DATA_COUNTER_W, 3, width of data-bit index counter (covers 0..MAX_UART_DATA_W-1)
STOP_CONF_W, 2, width of stop-bit config field
DATA_CONF_W, 2, width of data-length config field
SAMPLE_COUNT_W, 4, width of oversample tick counter (16 ticks per bit)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-low reset
baud_en_i  in  1  one-clk oversample tick, 16 per bit period
tx_en_i  in  1  transmitter enable; frames start only while high
tx_start_i  in  1  start request (direct mode) / FIFO-not-empty (FIFO mode)
tx_conf_i  in  DATA_CONF_W+STOP_CONF_W+1  [4:3] data length, [2:1] stop bits, [0] parity enable
tx_data_i  in  MAX_UART_DATA_W  word to send
tx_fifo_en_i  in  1  1 = data sourced from external TX FIFO
tx_done_o  out  1  one-cycle pulse at end of frame
tx_busy_o  out  1  high while a frame is in progress
uart_tx_o  out  1  serial line, idle high
tx_fifo_pop_o  out  1  one-cycle FIFO pop strobe

Behaviour:
- Reset (rst_i=0 at clk edge): state IDLE, uart_tx_o=1, tx_busy_o=0, tx_done_o=0, tx_fifo_pop_o=0, all counters 0. Reset mid-frame aborts immediately; no done pulse.
- Config decode: data length 00=5, 01=6, 10=7, 11=8 bits. Stop 00=1, 01=1.5 (24 ticks), 10=2, 11=2. Parity bit 0=none, 1=even parity over the active data bits. tx_data_i bits above the configured length are ignored.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: uart_tx_o=1. On an edge with tx_en_i=1 and tx_start_i=1: latch tx_data_i and tx_conf_i, go to START, set tx_busy_o=1. uart_tx_o=0 from the next cycle. The latched copies stay in use for the whole frame, so input changes mid-frame have no effect.
- FIFO mode (tx_fifo_en_i=1): the same start condition also asserts tx_fifo_pop_o for exactly that one following cycle. With tx_fifo_en_i=0, tx_fifo_pop_o stays 0.
- Tick counter increments only on baud_en_i=1. A bit ends on its 16th tick, at which point the counter wraps to 0 and the state/bit index advances. With baud_en_i held high, each bit is 16 clk cycles.
- START: uart_tx_o=0 for one bit period.
- DATA: send latched data LSB first. The bit index runs 0..len-1. After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: one bit period; uart_tx_o = XOR of the active data bits (even parity).
- STOP: uart_tx_o=1 for 16, 24 or 32 ticks.
- Frame end: on the final stop tick, return to IDLE. In the next cycle tx_busy_o=0 and tx_done_o=1 for exactly one cycle.
- A new frame may start in the cycle after done (back-to-back).
- tx_start_i while busy is ignored; requests are not queued.
- tx_en_i dropping mid-frame does not abort; the frame completes. No new frame starts while tx_en_i=0.
- baud_en_i=0 freezes the frame; the line holds its current level.
- Frame length in ticks = 16*(1 + len + parity) + stop ticks. Example: 8N1 = 160 ticks.

Test Plan:
- Reset held 50 cycles, then release; baud_en_i=1, tx_en_i=1, conf=5'b11000, data=0xAA, 1-cycle start -> line reads 0 then bits 0,1,0,1,0,1,0,1 then 1, each 16 clk; busy high throughout; done pulses once 160 ticks after start; pop stays 0.
- conf=5'b00001 (5 data bits, even parity), data=0x13 -> bits 1,1,0,0,1; parity bit 1; one stop bit; frame is 128 ticks.
- conf=5'b11100 (2 stop bits), data=0x00 -> stop level high for 32 ticks, then done; conf=5'b11010 -> stop high for 24 ticks.
- tx_start_i pulsed mid-frame, and tx_start_i=1 with tx_en_i=0 -> no extra frame, no glitch on the line; frame in progress still completes after tx_en_i is dropped.
- tx_fifo_en_i=1, tx_start_i held high -> pop pulses one cycle at each frame start; frames are back-to-back with one done pulse per frame.
- rst_i low mid-DATA -> next cycle line=1, busy=0, no done pulse; baud_en_i toggling every 4 clk stretches each bit to 64 clk.
